hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage CPU in each ring node. Sits beside the ID stage and drives the enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use and branch-operand hazards, freezes the pipe while data memory/NIC is not ready, and runs a drain/halt handshake so the node can be quiesced for ring configuration.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle and memory-wait counters
- TIMEOUT, 255, memory-wait cycles after which mem_timeout sets (must be < 2^CNT_W)

Ports (bit 0 is the MSB):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ID_valid  in  1  IF/ID holds a real instruction
- ID_rA  in  [0:4]  source register A of the ID instruction
- ID_src2  in  [0:4]  register on RF read port 2 (rB for R-type, rD otherwise)
- ID_is_br  in  1  ID instruction is bez/bnez
- ID_br_ctrl  in  1  branch in ID resolved taken
- EX_rD  in  [0:4]; EX_wrEn  in  1; EX_memEn  in  1; EX_memwrEn  in  1  ID/EX stage state
- MEM_rD  in  [0:4]; MEM_wrEn  in  1; MEM_memEn  in  1  EX/MEM stage state
- MEM_ready  in  1  data memory/NIC completes MEM-stage access this cycle
- halt_req  in  1  request to drain and halt the core (level)
- PC_en  out  1  PC register load enable
- pc_sel_br  out  1  PC loads ID_br_pc instead of PC+4
- IF_ID_en  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID loads a bubble
- ID_EX_en  out  1  ID/EX load enable
- ID_EX_bubble  out  1  ID/EX loads a bubble (wrEn/memEn cleared)
- pipe_freeze  out  1  EX/MEM and MEM/WB hold
- halt_ack  out  1  core drained and halted
- mem_timeout  out  1  sticky: a memory wait exceeded TIMEOUT
- stall_cycles  out  [0:CNT_W-1]  saturating count of cycles with PC_en=0 outside HALTED

## Operation
- States: RUN, DRAIN, HALTED. Memory wait tracked by wait_cnt, not a separate state.
- freeze = MEM_memEn & ~MEM_ready. Highest priority in every state: PC_en=IF_ID_en=ID_EX_en=0, pipe_freeze=1, no bubble, no flush, no state transition, drain_cnt holds.
- load_use = ID_valid & EX_wrEn & EX_memEn & ~EX_memwrEn & (EX_rD==ID_rA | EX_rD==ID_src2).
- br_haz = ID_valid & ID_is_br & ((EX_wrEn & EX_rD==ID_src2) | (MEM_wrEn & MEM_rD==ID_src2)).
- r0 is an ordinary register; no special-casing of index 0.
- RUN, no freeze:
  - if halt_req: go DRAIN, drain_cnt<=3; this cycle acts as a DRAIN cycle.
  - else if load_use|br_haz: PC_en=0, IF_ID_en=0, ID_EX_en=1, ID_EX_bubble=1.
  - else if ID_valid & ID_is_br & ID_br_ctrl: PC_en=1, pc_sel_br=1, IF_ID_flush=1, ID_EX_en=1.
  - else all enables 1, no bubble/flush.
- DRAIN, no freeze: PC_en=0, IF_ID_en=0 (held ID instruction not lost), ID_EX_bubble=1; drain_cnt decrements; at drain_cnt==1 go HALTED. halt_req drop in DRAIN: return RUN next cycle; held instruction issues normally.
- HALTED: same controls as DRAIN, halt_ack=1; halt_req=0 -> RUN next cycle.
- wait_cnt: +1 each freeze cycle, cleared when freeze=0; saturates; wait_cnt==TIMEOUT with freeze sets mem_timeout (cleared only by reset). Pipe keeps waiting.
- stall_cycles: +1 each cycle PC_en=0 and state≠HALTED; saturates at all-ones.

## Timing
- All control outputs combinational from current inputs and registered state; zero-cycle latency.
- State, drain_cnt, wait_cnt, mem_timeout, stall_cycles registered.
- reset asserted: state=RUN, counters 0, mem_timeout=0, halt_ack=0; forced outputs PC_en=0, IF_ID_en=0, ID_EX_en=1, ID_EX_bubble=1, IF_ID_flush=0, pc_sel_br=0, pipe_freeze=0. Reset mid-drain/mid-wait aborts immediately.
- Load-use/branch stall: exactly 1 cycle per hazard (bubble removes EX match; MEM match clears the following cycle), so br_haz worst case 2 cycles.
- Taken branch: 1-cycle penalty (one flushed fetch).
- Halt: halt_ack first high 3 non-freeze cycles after DRAIN entry; freeze cycles extend it 1:1.

## Test plan
- Load r3 in EX, ID add reads rA=r3 -> one cycle PC_en=0, ID_EX_bubble=1; next cycle all enables 1; stall_cycles=1.
- bez with src2=r5, EX_wrEn with EX_rD=r5 -> stall 1 cycle; then MEM match -> second stall; third cycle taken: pc_sel_br=1, IF_ID_flush=1.
- MEM_memEn=1, MEM_ready=0 for 300 cycles with TIMEOUT=255 plus concurrent load_use -> pipe_freeze=1, no bubble for all 300; mem_timeout rises at wait 255 and stays after MEM_ready=1.
- halt_req=1 in RUN, no freeze -> halt_ack high on 4th cycle; one freeze cycle inserted during drain -> halt_ack on 5th; halt_req=0 -> RUN, held instruction issues.
- Reset asserted during DRAIN -> outputs jump to reset values same cycle; after release state RUN, stall_cycles=0, halt_ack=0.
- stall_cycles with CNT_W=4: 20 stall cycles -> reads 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage node CPU: load-use and branch-operand
// stalls, memory-wait freeze with timeout flag, and a drain/halt handshake for ring configuration.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_valid,
    input  logic [0:4]       ID_rA,
    input  logic [0:4]       ID_src2,
    input  logic             ID_is_br,
    input  logic             ID_br_ctrl,
    input  logic [0:4]       EX_rD,
    input  logic             EX_wrEn,
    input  logic             EX_memEn,
    input  logic             EX_memwrEn,
    input  logic [0:4]       MEM_rD,
    input  logic             MEM_wrEn,
    input  logic             MEM_memEn,
    input  logic             MEM_ready,
    input  logic             halt_req,
    output logic             PC_en,
    output logic             pc_sel_br,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_en,
    output logic             ID_EX_bubble,
    output logic             pipe_freeze,
    output logic             halt_ack,
    output logic             mem_timeout,
    output logic [0:CNT_W-1] stall_cycles
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [0:CNT_W-1] ALL1 = '1;
    localparam logic [0:CNT_W-1] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [0:CNT_W-1] TMO  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [1:0]       drain_cnt;
    logic [0:CNT_W-1] wait_cnt;

    logic freeze, load_use, br_haz, taken, drain_ctl;

    assign freeze    = MEM_memEn & ~MEM_ready;
    assign load_use  = ID_valid & EX_wrEn & EX_memEn & ~EX_memwrEn &
                       ((EX_rD == ID_rA) | (EX_rD == ID_src2));
    assign br_haz    = ID_valid & ID_is_br &
                       ((EX_wrEn & (EX_rD == ID_src2)) | (MEM_wrEn & (MEM_rD == ID_src2)));
    assign taken     = ID_valid & ID_is_br & ID_br_ctrl;
    assign drain_ctl = (state != RUN) | halt_req;
    assign halt_ack  = (state == HALTED);

    // Defaults are the stall/drain pattern, which is also what reset forces.
    always_comb begin
        PC_en        = 1'b0;
        pc_sel_br    = 1'b0;
        IF_ID_en     = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_en     = 1'b1;
        ID_EX_bubble = 1'b1;
        pipe_freeze  = 1'b0;
        if (!reset) begin
            if (freeze) begin
                ID_EX_en     = 1'b0;
                ID_EX_bubble = 1'b0;
                pipe_freeze  = 1'b1;
            end else if (!drain_ctl && !(load_use | br_haz)) begin
                PC_en        = 1'b1;
                IF_ID_en     = 1'b1;
                ID_EX_bubble = 1'b0;
                pc_sel_br    = taken;
                IF_ID_flush  = taken;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= 2'd0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (freeze) begin
                if (wait_cnt != ALL1) wait_cnt <= wait_cnt + ONE;
                if (wait_cnt == TMO) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (!PC_en && state != HALTED && stall_cycles != ALL1)
                stall_cycles <= stall_cycles + ONE;

            // The RUN cycle that sees halt_req is the first of three drain cycles.
            if (!freeze) begin
                case (state)
                    RUN: if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd3;
                    end
                    DRAIN: if (!halt_req) begin
                        state <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                        if (drain_cnt == 2'd2) state <= HALTED;
                    end
                    HALTED: if (!halt_req) state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level reference model checked every cycle on two
// instances (default widths and a 4-bit counter variant), plus literal expectations per scenario.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ID_valid, ID_is_br, ID_br_ctrl;
    logic [0:4] ID_rA, ID_src2, EX_rD, MEM_rD;
    logic       EX_wrEn, EX_memEn, EX_memwrEn, MEM_wrEn, MEM_memEn, MEM_ready, halt_req;

    logic        PC_en, pc_sel_br, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, pipe_freeze, halt_ack, mem_timeout;
    logic [0:15] stall_cycles;
    logic        PC_en4, pc_sel_br4, IF_ID_en4, IF_ID_flush4, ID_EX_en4, ID_EX_bubble4, pipe_freeze4, halt_ack4, mem_timeout4;
    logic [0:3]  stall_cycles4;

    logic [7:0] ctl, ctl4;
    assign ctl  = {PC_en, pc_sel_br, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, pipe_freeze, halt_ack};
    assign ctl4 = {PC_en4, pc_sel_br4, IF_ID_en4, IF_ID_flush4, ID_EX_en4, ID_EX_bubble4, pipe_freeze4, halt_ack4};

    // {PC_en, pc_sel_br, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, pipe_freeze, halt_ack}
    localparam logic [7:0] C_STALL   = 8'b0000_1100;
    localparam logic [7:0] C_RUN     = 8'b1010_1000;
    localparam logic [7:0] C_TAKEN   = 8'b1111_1000;
    localparam logic [7:0] C_FRZ     = 8'b0000_0010;
    localparam logic [7:0] C_FRZ_ACK = 8'b0000_0011;
    localparam logic [7:0] C_HALT    = 8'b0000_1101;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rA(ID_rA), .ID_src2(ID_src2),
        .ID_is_br(ID_is_br), .ID_br_ctrl(ID_br_ctrl), .EX_rD(EX_rD), .EX_wrEn(EX_wrEn),
        .EX_memEn(EX_memEn), .EX_memwrEn(EX_memwrEn), .MEM_rD(MEM_rD), .MEM_wrEn(MEM_wrEn),
        .MEM_memEn(MEM_memEn), .MEM_ready(MEM_ready), .halt_req(halt_req),
        .PC_en(PC_en), .pc_sel_br(pc_sel_br), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_en(ID_EX_en), .ID_EX_bubble(ID_EX_bubble), .pipe_freeze(pipe_freeze),
        .halt_ack(halt_ack), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.CNT_W(4), .TIMEOUT(10)) dut4 (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rA(ID_rA), .ID_src2(ID_src2),
        .ID_is_br(ID_is_br), .ID_br_ctrl(ID_br_ctrl), .EX_rD(EX_rD), .EX_wrEn(EX_wrEn),
        .EX_memEn(EX_memEn), .EX_memwrEn(EX_memwrEn), .MEM_rD(MEM_rD), .MEM_wrEn(MEM_wrEn),
        .MEM_memEn(MEM_memEn), .MEM_ready(MEM_ready), .halt_req(halt_req),
        .PC_en(PC_en4), .pc_sel_br(pc_sel_br4), .IF_ID_en(IF_ID_en4), .IF_ID_flush(IF_ID_flush4),
        .ID_EX_en(ID_EX_en4), .ID_EX_bubble(ID_EX_bubble4), .pipe_freeze(pipe_freeze4),
        .halt_ack(halt_ack4), .mem_timeout(mem_timeout4), .stall_cycles(stall_cycles4)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=running, 1=draining, 2=halted
    int  m_mode  = 0;
    int  m_done  = 0;
    int  m_wait  = 0;
    int  m_stall = 0;
    bit  m_to    = 0;
    bit  m_to4   = 0;

    function automatic logic [7:0] model_ctl();
        bit frz, haz, ld, ack;
        frz = MEM_memEn && !MEM_ready;
        ld  = ID_valid && EX_wrEn && EX_memEn && !EX_memwrEn && (EX_rD == ID_rA || EX_rD == ID_src2);
        haz = ld || (ID_valid && ID_is_br &&
              ((EX_wrEn && EX_rD == ID_src2) || (MEM_wrEn && MEM_rD == ID_src2)));
        ack = (m_mode == 2);
        if (reset)                          return C_STALL;
        if (frz)                            return ack ? C_FRZ_ACK : C_FRZ;
        if (m_mode != 0 || halt_req)        return ack ? C_HALT : C_STALL;
        if (haz)                            return C_STALL;
        if (ID_valid && ID_is_br && ID_br_ctrl) return C_TAKEN;
        return C_RUN;
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        bit frz;
        if (reset) begin
            m_mode = 0; m_done = 0; m_wait = 0; m_stall = 0; m_to = 0; m_to4 = 0;
        end
        e = model_ctl();
        check("ctl", ctl, e);
        check("ctl4", ctl4, e);
        check("mem_timeout", mem_timeout, m_to);
        check("mem_timeout4", mem_timeout4, m_to4);
        check("stall_cycles", stall_cycles, (m_stall > 65535) ? 65535 : m_stall);
        check("stall_cycles4", stall_cycles4, (m_stall > 15) ? 15 : m_stall);
        if (!reset) begin
            frz = MEM_memEn && !MEM_ready;
            if (!e[7] && m_mode != 2) m_stall++;
            if (frz) begin
                if (m_wait >= 255) m_to = 1;
                if (m_wait >= 10) m_to4 = 1;
                m_wait++;
            end else begin
                m_wait = 0;
                case (m_mode)
                    0: if (halt_req) begin m_mode = 1; m_done = 1; end
                    1: if (!halt_req) m_mode = 0;
                       else begin m_done++; if (m_done == 3) m_mode = 2; end
                    default: if (!halt_req) m_mode = 0;
                endcase
            end
        end
    end

    task automatic clear();
        ID_valid = 0; ID_is_br = 0; ID_br_ctrl = 0; ID_rA = 0; ID_src2 = 0; EX_rD = 0; MEM_rD = 0;
        EX_wrEn = 0; EX_memEn = 0; EX_memwrEn = 0; MEM_wrEn = 0; MEM_memEn = 0; MEM_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear();
        halt_req = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #4 check("rst_ctl", ctl, C_STALL);
        check("rst_stall", stall_cycles, 0);
        check("rst_timeout", mem_timeout, 0);
        cyc(); reset = 0; #3 check("idle", ctl, C_RUN);

        // load-use: one stall, then the bubble clears the EX match
        cyc(); ID_valid = 1; ID_rA = 3; ID_src2 = 7; EX_rD = 3; EX_wrEn = 1; EX_memEn = 1;
        #3 check("lu_stall", ctl, C_STALL);
        cyc(); EX_wrEn = 0; EX_memEn = 0; MEM_rD = 3; MEM_wrEn = 1; MEM_memEn = 1; MEM_ready = 1;
        #3 check("lu_go", ctl, C_RUN);
        check("lu_cnt", stall_cycles, 1);

        // branch operand in EX, then in MEM, then taken
        cyc(); clear(); ID_valid = 1; ID_is_br = 1; ID_br_ctrl = 1; ID_rA = 9; ID_src2 = 5;
        EX_rD = 5; EX_wrEn = 1;
        #3 check("br_ex", ctl, C_STALL);
        cyc(); EX_wrEn = 0; MEM_rD = 5; MEM_wrEn = 1;
        #3 check("br_mem", ctl, C_STALL);
        cyc(); MEM_wrEn = 0;
        #3 check("br_taken", ctl, C_TAKEN);
        check("br_cnt", stall_cycles, 3);

        // r0 is not special; a store in EX is not a load-use
        cyc(); clear(); ID_valid = 1; ID_rA = 4; ID_src2 = 0; EX_rD = 0; EX_wrEn = 1; EX_memEn = 1;
        #3 check("r0_stall", ctl, C_STALL);
        cyc(); EX_memwrEn = 1;
        #3 check("store_no_stall", ctl, C_RUN);

        // 300-cycle memory wait with a concurrent load-use
        cyc(); clear(); ID_valid = 1; ID_rA = 3; EX_rD = 3; EX_wrEn = 1; EX_memEn = 1;
        MEM_memEn = 1; MEM_ready = 0;
        for (int i = 0; i < 300; i++) begin
            if (i != 0) cyc();
            #3;
            if (i == 0)   check("frz_ctl", ctl, C_FRZ);
            if (i == 255) check("to_before", mem_timeout, 0);
            if (i == 256) check("to_after", mem_timeout, 1);
        end
        cyc(); MEM_ready = 1;
        #3 check("frz_end", ctl, C_STALL);
        check("to_sticky", mem_timeout, 1);
        cyc(); clear();
        #3 check("to_sticky2", mem_timeout, 1);
        check("stall_sum", stall_cycles, 305);
        check("stall_sum4", stall_cycles4, 15);

        // halt without freeze: ack on the 4th cycle
        cyc(); halt_req = 1; ID_valid = 1; ID_rA = 1; ID_src2 = 2;
        #3 check("h1", ctl, C_STALL);
        cyc(); #3 check("h2", ctl, C_STALL);
        cyc(); #3 check("h3", ctl, C_STALL);
        cyc(); #3 check("h4", ctl, C_HALT);
        cyc(); halt_req = 0; #3 check("h_rel", ctl, C_HALT);
        cyc(); #3 check("h_run", ctl, C_RUN);

        // halt with one freeze cycle: ack on the 5th cycle
        cyc(); halt_req = 1; #3 check("hf1", ctl, C_STALL);
        cyc(); MEM_memEn = 1; MEM_ready = 0; #3 check("hf2", ctl, C_FRZ);
        cyc(); MEM_memEn = 0; #3 check("hf3", ctl, C_STALL);
        cyc(); #3 check("hf4", ctl, C_STALL);
        cyc(); #3 check("hf5", ctl, C_HALT);
        cyc(); halt_req = 0; MEM_memEn = 1; #3 check("hf_frz", ctl, C_FRZ_ACK);
        cyc(); MEM_memEn = 0; #3 check("hf_rel", ctl, C_HALT);
        cyc(); #3 check("hf_run", ctl, C_RUN);

        // drain aborted by dropping halt_req
        cyc(); halt_req = 1;
        cyc();
        cyc(); halt_req = 0; #3 check("abort_drain", ctl, C_STALL);
        cyc(); #3 check("abort_run", ctl, C_RUN);

        // reset in the middle of a drain
        cyc(); halt_req = 1;
        cyc();
        cyc(); reset = 1;
        #3 check("rst_drain_ctl", ctl, C_STALL);
        check("rst_drain_cnt", stall_cycles, 0);
        check("rst_drain_to", mem_timeout, 0);
        cyc(); reset = 0; halt_req = 0;
        #3 check("rst_drain_run", ctl, C_RUN);

        // 20 stall cycles saturate the 4-bit counter
        cyc(); ID_valid = 1; ID_rA = 6; EX_rD = 6; EX_wrEn = 1; EX_memEn = 1;
        for (int i = 1; i < 20; i++) cyc();
        cyc(); clear();
        #3 check("sat4", stall_cycles4, 15);
        check("sat16", stall_cycles, 20);

        cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
